router_fsm: RTL and testbench

ROUTER_FSM -- requirements
Module: router_fsm

---
 rtl/router_fsm.sv | 125 ++++++++++++
 tb/tb_router_fsm.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_fsm.sv
// Packet router control FSM: tracks header decode, payload load, full stalls and parity check.
// Optional per-destination soft-reset handling is enabled with `define ROUTER_FSM_SOFT_RESET_EN.
module router_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic       parity_done,
  input  logic       fifo_full,
  input  logic       low_pkt_valid,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic [1:0] data_in,
  output logic       busy,
  output logic       detect_add,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       lfd_state
);

  typedef enum logic [2:0] {
    DA  = 3'd0,
    LFD = 3'd1,
    LD  = 3'd2,
    FFS = 3'd3,
    LAF = 3'd4,
    LP  = 3'd5,
    CPE = 3'd6,
    WTE = 3'd7
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] addr, addr_nxt;
  logic       empty_din, empty_addr, soft_hit;

  always_comb begin
    empty_din = 1'b0;
    case (data_in)
      2'd0:    empty_din = fifo_empty_0;
      2'd1:    empty_din = fifo_empty_1;
      2'd2:    empty_din = fifo_empty_2;
      default: empty_din = 1'b0;
    endcase
  end

  always_comb begin
    empty_addr = 1'b0;
    case (addr)
      2'd0:    empty_addr = fifo_empty_0;
      2'd1:    empty_addr = fifo_empty_1;
      2'd2:    empty_addr = fifo_empty_2;
      default: empty_addr = 1'b0;
    endcase
  end

`ifdef ROUTER_FSM_SOFT_RESET_EN
  // Only the timeout of the destination currently being served aborts the packet.
  assign soft_hit = (soft_reset_0 && addr == 2'd0) ||
                    (soft_reset_1 && addr == 2'd1) ||
                    (soft_reset_2 && addr == 2'd2);
`else
  logic unused_soft;
  assign unused_soft = ^{soft_reset_0, soft_reset_1, soft_reset_2};
  assign soft_hit    = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= DA;
      addr  <= 2'd0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    case (state)
      DA: if (pkt_valid && data_in != 2'd3) begin
        addr_nxt  = data_in;
        state_nxt = empty_din ? LFD : WTE;
      end
      LFD: state_nxt = LD;
      LD: begin
        if (fifo_full)       state_nxt = FFS;
        else if (!pkt_valid) state_nxt = LP;
      end
      FFS: if (!fifo_full) state_nxt = LAF;
      LAF: begin
        if (parity_done)        state_nxt = DA;
        else if (low_pkt_valid) state_nxt = LP;
        else                    state_nxt = LD;
      end
      LP:  state_nxt = CPE;
      CPE: state_nxt = fifo_full ? FFS : DA;
      WTE: if (empty_addr) state_nxt = LFD;
      default: state_nxt = DA;
    endcase
    // A soft reset also suppresses any header latch in the same cycle.
    if (soft_hit) begin
      state_nxt = DA;
      addr_nxt  = addr;
    end
  end

  always_comb begin
    detect_add    = (state == DA);
    lfd_state     = (state == LFD);
    ld_state      = (state == LD);
    full_state    = (state == FFS);
    laf_state     = (state == LAF);
    rst_int_reg   = (state == CPE);
    write_enb_reg = (state == LD) || (state == LAF) || (state == LP);
    busy          = !((state == DA) || (state == LD));
  end

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed scenario tables plus randomized traffic against a spec-level model.
module tb_router_fsm;

  localparam int S_DA = 0, S_LFD = 1, S_LD = 2, S_FFS = 3, S_LAF = 4, S_LP = 5, S_CPE = 6, S_WTE = 7;

  typedef struct packed {
    logic       pv, ff, lpv, pd;
    logic [1:0] din;
    logic [2:0] emp;
    logic [2:0] exp;
  } stim_t;

  logic clock = 1'b0, resetn = 1'b0;
  logic pkt_valid = 0, parity_done = 0, fifo_full = 0, low_pkt_valid = 0;
  logic soft_reset_0 = 0, soft_reset_1 = 0, soft_reset_2 = 0;
  logic fifo_empty_0 = 1, fifo_empty_1 = 1, fifo_empty_2 = 1;
  logic [1:0] data_in = 2'd0;
  logic busy, detect_add, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, lfd_state;
  logic [7:0] outs;
  int total = 0, bad = 0;

  router_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .parity_done(parity_done),
    .fifo_full(fifo_full), .low_pkt_valid(low_pkt_valid),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .data_in(data_in), .busy(busy), .detect_add(detect_add), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .lfd_state(lfd_state)
  );

  always #5 clock = ~clock;

  assign outs = {busy, detect_add, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, lfd_state};

  // Output table: {busy, detect_add, ld, laf, full, write_enb, rst_int, lfd}
  function automatic logic [7:0] exp_outs(input int s);
    case (s)
      S_DA:    return 8'b0100_0000;
      S_LFD:   return 8'b1000_0001;
      S_LD:    return 8'b0010_0100;
      S_FFS:   return 8'b1000_1000;
      S_LAF:   return 8'b1001_0100;
      S_LP:    return 8'b1000_0100;
      S_CPE:   return 8'b1000_0010;
      default: return 8'b1000_0000;
    endcase
  endfunction

  function automatic stim_t mk(input logic pv, ff, lpv, pd, input logic [1:0] din,
                               input logic [2:0] emp, input int exp);
    mk = '{pv: pv, ff: ff, lpv: lpv, pd: pd, din: din, emp: emp, exp: exp[2:0]};
  endfunction

  task automatic apply(input stim_t s);
    pkt_valid = s.pv; fifo_full = s.ff; low_pkt_valid = s.lpv; parity_done = s.pd;
    data_in = s.din; {fifo_empty_2, fifo_empty_1, fifo_empty_0} = s.emp;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    apply(mk(0, 0, 0, 0, 2'd0, 3'b111, S_DA));
    soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
    resetn = 0;
    tick();
    resetn = 1;
  endtask

  task automatic test_reset();
    resetn = 0;
    #1;
    total++;
    if (outs !== exp_outs(S_DA)) begin bad++; $display("FAIL reset_held got=%b want=%b", outs, exp_outs(S_DA)); end
    tick();
    resetn = 1;
    tick();
    total++;
    if (outs !== exp_outs(S_DA)) begin bad++; $display("FAIL reset_release got=%b want=%b", outs, exp_outs(S_DA)); end
  endtask

  task automatic test_short_packet();
    stim_t seq [7];
    seq[0] = mk(1, 0, 0, 0, 2'd3, 3'b111, S_DA);   // address 3 is ignored
    seq[1] = mk(1, 0, 0, 0, 2'd1, 3'b010, S_DA);
    seq[2] = mk(0, 0, 0, 0, 2'd0, 3'b010, S_LFD);
    seq[3] = mk(0, 0, 0, 0, 2'd0, 3'b010, S_LD);
    seq[4] = mk(0, 0, 0, 0, 2'd0, 3'b010, S_LP);
    seq[5] = mk(0, 0, 0, 0, 2'd0, 3'b010, S_CPE);
    seq[6] = mk(0, 0, 0, 0, 2'd0, 3'b010, S_DA);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (outs !== exp_outs(int'(seq[i].exp))) begin
        bad++; $display("FAIL short_pkt step%0d got=%b want=%b", i, outs, exp_outs(int'(seq[i].exp)));
      end
      apply(seq[i]);
      tick();
    end
  endtask

  task automatic test_stall_end();
    stim_t seq [11];
    seq[0]  = mk(1, 0, 0, 0, 2'd0, 3'b111, S_DA);
    seq[1]  = mk(1, 0, 0, 0, 2'd0, 3'b111, S_LFD);
    seq[2]  = mk(1, 1, 0, 0, 2'd0, 3'b111, S_LD);
    seq[3]  = mk(0, 1, 1, 0, 2'd0, 3'b111, S_FFS);
    seq[4]  = mk(0, 1, 1, 0, 2'd0, 3'b111, S_FFS);
    seq[5]  = mk(0, 1, 1, 0, 2'd0, 3'b111, S_FFS);
    seq[6]  = mk(0, 0, 1, 0, 2'd0, 3'b111, S_FFS);
    seq[7]  = mk(0, 0, 1, 0, 2'd0, 3'b111, S_LAF);
    seq[8]  = mk(0, 0, 0, 0, 2'd0, 3'b111, S_LP);
    seq[9]  = mk(0, 0, 0, 0, 2'd0, 3'b111, S_CPE);
    seq[10] = mk(0, 0, 0, 0, 2'd0, 3'b111, S_DA);
    for (int i = 0; i < 11; i++) begin
      total++;
      if (outs !== exp_outs(int'(seq[i].exp))) begin
        bad++; $display("FAIL stall_end step%0d got=%b want=%b", i, outs, exp_outs(int'(seq[i].exp)));
      end
      apply(seq[i]);
      tick();
    end
  endtask

  task automatic test_stall_resume();
    stim_t seq [12];
    seq[0]  = mk(1, 0, 0, 0, 2'd1, 3'b111, S_DA);
    seq[1]  = mk(1, 0, 0, 0, 2'd1, 3'b111, S_LFD);
    seq[2]  = mk(1, 1, 0, 0, 2'd1, 3'b111, S_LD);
    seq[3]  = mk(1, 1, 0, 0, 2'd1, 3'b111, S_FFS);
    seq[4]  = mk(1, 1, 0, 0, 2'd1, 3'b111, S_FFS);
    seq[5]  = mk(1, 0, 0, 0, 2'd1, 3'b111, S_FFS);
    seq[6]  = mk(1, 0, 0, 0, 2'd1, 3'b111, S_LAF);
    seq[7]  = mk(1, 0, 0, 0, 2'd1, 3'b111, S_LD);
    seq[8]  = mk(0, 0, 0, 0, 2'd1, 3'b111, S_LD);
    seq[9]  = mk(0, 0, 0, 0, 2'd1, 3'b111, S_LP);
    seq[10] = mk(0, 0, 0, 0, 2'd1, 3'b111, S_CPE);
    seq[11] = mk(0, 0, 0, 0, 2'd1, 3'b111, S_DA);
    for (int i = 0; i < 12; i++) begin
      total++;
      if (outs !== exp_outs(int'(seq[i].exp))) begin
        bad++; $display("FAIL stall_resume step%0d got=%b want=%b", i, outs, exp_outs(int'(seq[i].exp)));
      end
      apply(seq[i]);
      tick();
    end
  endtask

  task automatic test_full_at_parity();
    stim_t seq [9];
    seq[0] = mk(1, 0, 0, 0, 2'd2, 3'b111, S_DA);
    seq[1] = mk(0, 0, 0, 0, 2'd2, 3'b111, S_LFD);
    seq[2] = mk(0, 0, 0, 0, 2'd2, 3'b111, S_LD);
    seq[3] = mk(0, 0, 0, 0, 2'd2, 3'b111, S_LP);
    seq[4] = mk(0, 1, 0, 0, 2'd2, 3'b111, S_CPE);
    seq[5] = mk(0, 1, 0, 0, 2'd2, 3'b111, S_FFS);
    seq[6] = mk(0, 0, 0, 1, 2'd2, 3'b111, S_FFS);
    seq[7] = mk(0, 0, 1, 1, 2'd2, 3'b111, S_LAF);   // parity_done wins over low_pkt_valid
    seq[8] = mk(0, 0, 0, 0, 2'd2, 3'b111, S_DA);
    for (int i = 0; i < 9; i++) begin
      total++;
      if (outs !== exp_outs(int'(seq[i].exp))) begin
        bad++; $display("FAIL full_parity step%0d got=%b want=%b", i, outs, exp_outs(int'(seq[i].exp)));
      end
      apply(seq[i]);
      tick();
    end
  endtask

  task automatic test_busy_dest();
    stim_t seq [9];
    seq[0] = mk(1, 0, 0, 0, 2'd2, 3'b011, S_DA);
    seq[1] = mk(0, 0, 0, 0, 2'd0, 3'b011, S_WTE);
    seq[2] = mk(0, 0, 0, 0, 2'd2, 3'b011, S_WTE);   // data_in no longer selects the flag
    seq[3] = mk(0, 0, 0, 0, 2'd0, 3'b111, S_WTE);
    seq[4] = mk(0, 0, 0, 0, 2'd0, 3'b111, S_LFD);
    seq[5] = mk(0, 0, 0, 0, 2'd0, 3'b111, S_LD);
    seq[6] = mk(0, 0, 0, 0, 2'd0, 3'b111, S_LP);
    seq[7] = mk(0, 0, 0, 0, 2'd0, 3'b111, S_CPE);
    seq[8] = mk(0, 0, 0, 0, 2'd0, 3'b111, S_DA);
    for (int i = 0; i < 9; i++) begin
      total++;
      if (outs !== exp_outs(int'(seq[i].exp))) begin
        bad++; $display("FAIL busy_dest step%0d got=%b want=%b", i, outs, exp_outs(int'(seq[i].exp)));
      end
      apply(seq[i]);
      tick();
    end
  endtask

  task automatic test_soft_reset();
    int want;
    apply(mk(1, 0, 0, 0, 2'd2, 3'b011, S_DA));
    tick();
    apply(mk(0, 0, 0, 0, 2'd0, 3'b011, S_WTE));
    soft_reset_0 = 1; soft_reset_1 = 1;
    tick();
    total++;
    if (outs !== exp_outs(S_WTE)) begin bad++; $display("FAIL soft_other got=%b want=%b", outs, exp_outs(S_WTE)); end
    soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 1;
    tick();
`ifdef ROUTER_FSM_SOFT_RESET_EN
    want = S_DA;
`else
    want = S_WTE;
`endif
    total++;
    if (outs !== exp_outs(want)) begin bad++; $display("FAIL soft_match got=%b want=%b", outs, exp_outs(want)); end
    do_reset();
  endtask

  task automatic test_reset_midpacket();
    apply(mk(1, 0, 0, 0, 2'd2, 3'b111, S_DA));
    tick();
    tick();
    total++;
    if (outs !== exp_outs(S_LD)) begin bad++; $display("FAIL midrst_pre got=%b want=%b", outs, exp_outs(S_LD)); end
    fifo_full = 1;
    #2 resetn = 0;
    #1;
    total++;
    if (outs !== exp_outs(S_DA)) begin bad++; $display("FAIL midrst_async got=%b want=%b", outs, exp_outs(S_DA)); end
    tick();
    resetn = 1;
    apply(mk(0, 0, 0, 0, 2'd0, 3'b111, S_DA));
    tick();
    total++;
    if (outs !== exp_outs(S_DA)) begin bad++; $display("FAIL midrst_after got=%b want=%b", outs, exp_outs(S_DA)); end
  endtask

  // Reference model: next state and latched address from the transition rules.
  function automatic void ref_step(input int s, input int a, output int ns, output int na);
    logic [2:0] emp;
    emp = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    ns = s; na = a;
    case (s)
      S_DA:  if (pkt_valid && data_in != 2'd3) begin
               na = int'(data_in);
               ns = emp[data_in] ? S_LFD : S_WTE;
             end
      S_LFD: ns = S_LD;
      S_LD:  ns = fifo_full ? S_FFS : (!pkt_valid ? S_LP : S_LD);
      S_FFS: ns = fifo_full ? S_FFS : S_LAF;
      S_LAF: ns = parity_done ? S_DA : (low_pkt_valid ? S_LP : S_LD);
      S_LP:  ns = S_CPE;
      S_CPE: ns = fifo_full ? S_FFS : S_DA;
      default: ns = emp[a[1:0]] ? S_LFD : S_WTE;
    endcase
`ifdef ROUTER_FSM_SOFT_RESET_EN
    if ((soft_reset_0 && a == 0) || (soft_reset_1 && a == 1) || (soft_reset_2 && a == 2)) begin
      ns = S_DA; na = a;
    end
`endif
  endfunction

  task automatic test_random();
    int m_state = S_DA, m_addr = 0, ns, na;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        resetn = 0;
        #1;
        total++;
        if (outs !== exp_outs(S_DA)) begin bad++; $display("FAIL rand_reset cyc%0d got=%b want=%b", i, outs, exp_outs(S_DA)); end
        m_state = S_DA; m_addr = 0;
        tick();
        resetn = 1;
        continue;
      end
      total++;
      if (outs !== exp_outs(m_state)) begin
        bad++; $display("FAIL random cyc%0d state=%0d got=%b want=%b", i, m_state, outs, exp_outs(m_state));
      end
      pkt_valid     = ($urandom_range(0, 3) != 0);
      fifo_full     = ($urandom_range(0, 3) == 0);
      low_pkt_valid = $urandom_range(0, 1) == 1;
      parity_done   = ($urandom_range(0, 3) == 0);
      data_in       = 2'($urandom_range(0, 3));
      fifo_empty_0  = ($urandom_range(0, 3) != 0);
      fifo_empty_1  = ($urandom_range(0, 3) != 0);
      fifo_empty_2  = ($urandom_range(0, 3) != 0);
      soft_reset_0  = ($urandom_range(0, 15) == 0);
      soft_reset_1  = ($urandom_range(0, 15) == 0);
      soft_reset_2  = ($urandom_range(0, 15) == 0);
      ref_step(m_state, m_addr, ns, na);
      tick();
      m_state = ns; m_addr = na;
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_short_packet();
    test_stall_end();
    test_stall_resume();
    test_full_at_parity();
    test_busy_dest();
    test_soft_reset();
    test_reset_midpacket();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
